// File: rtl/sad_result_uart_tx.sv
// sad_result_uart_tx
//   Reporting stage of the SAD processor. It captures each (x_in, y_in) match
//   result strobed by valid_in and sends it to the host as one 8N1 UART frame:
//     A5-style sync byte, {6'b0,x[9:8]}, x[7:0], {7'b0,y[8]}, y[7:0]
//   When SAD_TX_CHECKSUM_EN is defined, the frame also carries an XOR
//   checksum byte of bytes 1..4.
//   A one-deep pending register queues one result that arrives while a frame
//   is in flight. Any further result that arrives in that window is dropped
//   and latched in the overflow flag.
//
// Parameters
//   CLK_FREQ   system clock in Hz
//   BAUD       line rate; bit period DIV = CLK_FREQ/BAUD cycles (>= 2)
//   SYNC_BYTE  first byte of every frame
//
// Ports
//   clock          system clock, rising edge
//   notReset       asynchronous active-low reset
//   valid_in       one-cycle strobe; x_in/y_in hold a new result
//   x_in[9:0]      match column
//   y_in[8:0]      match row
//   TxD            serial line, idle high (registered)
//   busy           frame in flight or result pending
//   send_complete  one-cycle pulse after the last stop bit of a frame
//   overflow       sticky drop indicator, cleared only by reset

module sad_result_uart_tx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clock,
    input  logic       notReset,
    input  logic       valid_in,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    output logic       TxD,
    output logic       busy,
    output logic       send_complete,
    output logic       overflow
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

`ifdef SAD_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state, stateNext;
    logic [CNT_W-1:0] baudCnt, baudCntNext;
    logic [2:0]       bitIdx, bitIdxNext;
    logic [2:0]       byteIdx, byteIdxNext;
    logic [9:0]       frameX, pendX;
    logic [8:0]       frameY, pendY;
    logic             pendFull;
    logic             loadInput, loadPending;
    logic             bitEnd;
    logic             txNext;
    logic [7:0]       curByte;

    assign bitEnd = (baudCnt == CNT_LAST);

    // Byte currently on the line, selected from the captured result
    always_comb begin
        curByte = SYNC_BYTE;
        case (byteIdx)
            3'd0:    curByte = SYNC_BYTE;
            3'd1:    curByte = {6'b0, frameX[9:8]};
            3'd2:    curByte = frameX[7:0];
            3'd3:    curByte = {7'b0, frameY[8]};
            3'd4:    curByte = frameY[7:0];
`ifdef SAD_TX_CHECKSUM_EN
            3'd5:    curByte = {6'b0, frameX[9:8]} ^ frameX[7:0]
                             ^ {7'b0, frameY[8]} ^ frameY[7:0];
`endif
            default: curByte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        stateNext   = state;
        baudCntNext = baudCnt + CNT_W'(1);
        bitIdxNext  = bitIdx;
        byteIdxNext = byteIdx;
        loadInput   = 1'b0;
        loadPending = 1'b0;
        case (state)
            S_IDLE: begin
                baudCntNext = '0;
                byteIdxNext = '0;
                if (valid_in) begin
                    stateNext = S_START;
                    loadInput = 1'b1;
                end
            end
            S_START: begin
                if (bitEnd) begin
                    stateNext   = S_DATA;
                    bitIdxNext  = '0;
                    baudCntNext = '0;
                end
            end
            S_DATA: begin
                if (bitEnd) begin
                    baudCntNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = S_STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bitEnd) begin
                    baudCntNext = '0;
                    if (byteIdx == LAST_BYTE) begin
                        stateNext = S_DONE;
                    end else begin
                        stateNext   = S_START;
                        byteIdxNext = byteIdx + 3'd1;
                    end
                end
            end
            S_DONE: begin
                // Pending result has priority; a strobe in this cycle is
                // either queued behind it or sent directly, never dropped.
                baudCntNext = '0;
                byteIdxNext = '0;
                if (pendFull) begin
                    stateNext   = S_START;
                    loadPending = 1'b1;
                end else if (valid_in) begin
                    stateNext = S_START;
                    loadInput = 1'b1;
                end else begin
                    stateNext = S_IDLE;
                end
            end
            default: begin
                stateNext   = S_IDLE;
                baudCntNext = '0;
            end
        endcase
    end

    // TxD is registered from the next state so the line never glitches.
    // Entering DATA never changes byteIdx, so curByte is already valid.
    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            S_START: txNext = 1'b0;
            S_DATA:  txNext = curByte[bitIdxNext];
            default: txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state    <= S_IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            byteIdx  <= '0;
            TxD      <= 1'b1;
            frameX   <= '0;
            frameY   <= '0;
            pendX    <= '0;
            pendY    <= '0;
            pendFull <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= stateNext;
            baudCnt <= baudCntNext;
            bitIdx  <= bitIdxNext;
            byteIdx <= byteIdxNext;
            TxD     <= txNext;

            if (loadInput) begin
                frameX <= x_in;
                frameY <= y_in;
            end else if (loadPending) begin
                frameX <= pendX;
                frameY <= pendY;
            end

            if (state == S_DONE) begin
                if (pendFull) begin
                    // Pending moves out; a same-cycle strobe refills it
                    pendFull <= valid_in;
                    if (valid_in) begin
                        pendX <= x_in;
                        pendY <= y_in;
                    end
                end
            end else if (state != S_IDLE && valid_in) begin
                if (!pendFull) begin
                    pendX    <= x_in;
                    pendY    <= y_in;
                    pendFull <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign send_complete = (state == S_DONE);
    assign busy          = (state != S_IDLE) && !((state == S_DONE) && !pendFull);

endmodule
